// File: rtl/dram_ctrl.sv
// Single-outstanding open-page DRAM command controller: converts one valid/ready
// word request at a time into PRE/ACT/RD/WR commands and returns one response.
module dram_ctrl #(
    parameter int ROW_BITS = 11,
    parameter int COL_BITS = 10,
    parameter int T_RP     = 5,
    parameter int T_RCD    = 5,
    parameter int T_WR     = 5,
    parameter int T_OUT    = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    input  logic [3:0]          req_wstrb,
    output logic                resp_valid,
    output logic [31:0]         resp_rdata,
    output logic                resp_err,
    output logic                DRAM_CSn,
    output logic [3:0]          DRAM_WEn,
    output logic                DRAM_RASn,
    output logic                DRAM_CASn,
    output logic [ROW_BITS-1:0] DRAM_A,
    output logic [31:0]         DRAM_D,
    input  logic [31:0]         DRAM_Q,
    input  logic                DRAM_valid
);

    localparam int T_MAX_A = (T_RP > T_RCD) ? T_RP : T_RCD;
    localparam int T_MAX_B = (T_WR > T_OUT) ? T_WR : T_OUT;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int CW      = $clog2(T_MAX + 1);

    // Wait states last (T-1) cycles because the command cycle itself counts toward T.
    localparam logic [CW-1:0] TRP_LAST  = CW'((T_RP  > 1) ? T_RP  - 2 : 0);
    localparam logic [CW-1:0] TRCD_LAST = CW'((T_RCD > 1) ? T_RCD - 2 : 0);
    localparam logic [CW-1:0] TWR_LAST  = CW'(T_WR - 1);
    localparam logic [CW-1:0] TOUT_LAST = CW'(T_OUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_TRP,
        S_ACT,
        S_TRCD,
        S_CAS,
        S_RWAIT,
        S_WWAIT,
        S_RESP
    } state_t;

    state_t state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic                open_valid_reg, open_valid_next;
    logic [ROW_BITS-1:0] open_row_reg, open_row_next;

    logic                write_reg, write_next;
    logic [ROW_BITS-1:0] row_reg, row_next;
    logic [COL_BITS-1:0] col_reg, col_next;
    logic [31:0]         wdata_reg, wdata_next;
    logic [3:0]          wstrb_reg, wstrb_next;

    logic        req_ready_reg, req_ready_next;
    logic        resp_valid_reg, resp_valid_next;
    logic [31:0] resp_rdata_reg, resp_rdata_next;
    logic        resp_err_reg, resp_err_next;

    logic                csn_reg, csn_next;
    logic [3:0]          wen_reg, wen_next;
    logic                rasn_reg, rasn_next;
    logic                casn_reg, casn_next;
    logic [ROW_BITS-1:0] a_reg, a_next;
    logic [31:0]         d_reg, d_next;

    logic [ROW_BITS-1:0] req_row;
    logic [COL_BITS-1:0] req_col;
    logic [3:0]          wr_wen;
    logic                addr_unused;

    assign req_row     = req_addr[ROW_BITS+COL_BITS+1:COL_BITS+2];
    assign req_col     = req_addr[COL_BITS+1:2];
    assign addr_unused = ^{req_addr[31:ROW_BITS+COL_BITS+2], req_addr[1:0]};

    // Write enables are active low per byte lane.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wen
            assign wr_wen[gi] = ~wstrb_next[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            open_valid_reg <= 1'b0;
            open_row_reg   <= '0;
            write_reg      <= 1'b0;
            row_reg        <= '0;
            col_reg        <= '0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
            csn_reg        <= 1'b1;
            wen_reg        <= 4'hF;
            rasn_reg       <= 1'b1;
            casn_reg       <= 1'b1;
            a_reg          <= '0;
            d_reg          <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            open_valid_reg <= open_valid_next;
            open_row_reg   <= open_row_next;
            write_reg      <= write_next;
            row_reg        <= row_next;
            col_reg        <= col_next;
            wdata_reg      <= wdata_next;
            wstrb_reg      <= wstrb_next;
            req_ready_reg  <= req_ready_next;
            resp_valid_reg <= resp_valid_next;
            resp_rdata_reg <= resp_rdata_next;
            resp_err_reg   <= resp_err_next;
            csn_reg        <= csn_next;
            wen_reg        <= wen_next;
            rasn_reg       <= rasn_next;
            casn_reg       <= casn_next;
            a_reg          <= a_next;
            d_reg          <= d_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        open_valid_next = open_valid_reg;
        open_row_next   = open_row_reg;
        write_next      = write_reg;
        row_next        = row_reg;
        col_next        = col_reg;
        wdata_next      = wdata_reg;
        wstrb_next      = wstrb_reg;
        resp_rdata_next = resp_rdata_reg;
        resp_err_next   = resp_err_reg;

        case (state_reg)
            S_IDLE: begin
                if (req_valid && req_ready_reg) begin
                    write_next = req_write;
                    row_next   = req_row;
                    col_next   = req_col;
                    wdata_next = req_wdata;
                    wstrb_next = req_wstrb;
                    cnt_next   = '0;
                    if (open_valid_reg && (req_row == open_row_reg)) begin
                        state_next = S_CAS;
                    end else if (open_valid_reg) begin
                        state_next = S_PRE;
                    end else begin
                        state_next = S_ACT;
                    end
                end
            end
            S_PRE: begin
                cnt_next   = '0;
                state_next = (T_RP > 1) ? S_TRP : S_ACT;
            end
            S_TRP: begin
                if (cnt_reg == TRP_LAST) begin
                    state_next = S_ACT;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_ACT: begin
                open_valid_next = 1'b1;
                open_row_next   = row_reg;
                cnt_next        = '0;
                state_next      = (T_RCD > 1) ? S_TRCD : S_CAS;
            end
            S_TRCD: begin
                if (cnt_reg == TRCD_LAST) begin
                    state_next = S_CAS;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_CAS: begin
                cnt_next   = '0;
                state_next = write_reg ? S_WWAIT : S_RWAIT;
            end
            S_RWAIT: begin
                if (DRAM_valid) begin
                    resp_rdata_next = DRAM_Q;
                    resp_err_next   = 1'b0;
                    state_next      = S_RESP;
                end else if (cnt_reg == TOUT_LAST) begin
                    // A silent device leaves the row state unknown, so reopen next time.
                    resp_rdata_next = '0;
                    resp_err_next   = 1'b1;
                    open_valid_next = 1'b0;
                    state_next      = S_RESP;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_WWAIT: begin
                if (cnt_reg == TWR_LAST) begin
                    resp_err_next = 1'b0;
                    state_next    = S_RESP;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Pins are registered from the state being entered, so each command
    // occupies exactly the one cycle its state lasts.
    always_comb begin
        csn_next        = 1'b1;
        rasn_next       = 1'b1;
        casn_next       = 1'b1;
        wen_next        = 4'hF;
        a_next          = a_reg;
        d_next          = d_reg;
        req_ready_next  = (state_next == S_IDLE);
        resp_valid_next = (state_next == S_RESP);

        case (state_next)
            S_PRE: begin
                csn_next  = 1'b0;
                rasn_next = 1'b0;
                wen_next  = 4'h0;
            end
            S_ACT: begin
                csn_next  = 1'b0;
                rasn_next = 1'b0;
                a_next    = row_next;
            end
            S_CAS: begin
                csn_next  = 1'b0;
                casn_next = 1'b0;
                a_next    = ROW_BITS'(col_next);
                if (write_next) begin
                    wen_next = wr_wen;
                    d_next   = wdata_next;
                end
            end
            default: begin
            end
        endcase
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;
    assign DRAM_CSn   = csn_reg;
    assign DRAM_WEn   = wen_reg;
    assign DRAM_RASn  = rasn_reg;
    assign DRAM_CASn  = casn_reg;
    assign DRAM_A     = a_reg;
    assign DRAM_D     = d_reg;

endmodule

// File: tb/tb_dram_ctrl.sv
// Randomized scoreboard bench for dram_ctrl: a cycle-level open-page model predicts
// every DRAM command and every response; two monitors compare what the DUT does.
module tb_dram_ctrl;

    localparam int ROW_BITS = 11;
    localparam int COL_BITS = 10;
    localparam int T_RP     = 5;
    localparam int T_RCD    = 5;
    localparam int T_WR     = 5;
    localparam int T_OUT    = 64;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        DRAM_CSn;
    logic [3:0]  DRAM_WEn;
    logic        DRAM_RASn;
    logic        DRAM_CASn;
    logic [10:0] DRAM_A;
    logic [31:0] DRAM_D;
    logic [31:0] DRAM_Q;
    logic        DRAM_valid;

    dram_ctrl #(
        .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .T_RP(T_RP),
        .T_RCD(T_RCD), .T_WR(T_WR), .T_OUT(T_OUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .DRAM_CSn(DRAM_CSn), .DRAM_WEn(DRAM_WEn), .DRAM_RASn(DRAM_RASn),
        .DRAM_CASn(DRAM_CASn), .DRAM_A(DRAM_A), .DRAM_D(DRAM_D),
        .DRAM_Q(DRAM_Q), .DRAM_valid(DRAM_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cy;
        logic        rasn;
        logic        casn;
        logic [3:0]  wen;
        bit          chk_a;
        logic [10:0] a;
        bit          chk_d;
        logic [31:0] d;
        string       name;
    } cmd_t;

    typedef struct {
        int          cy;
        bit          is_write;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: which row the device has open and the last read result.
    bit          m_open  = 1'b0;
    int          m_row   = 0;
    logic [31:0] m_rdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic cmd_t mk(input int cy, input logic rasn, input logic casn,
                                input logic [3:0] wen, input bit chk_a, input logic [10:0] a,
                                input bit chk_d, input logic [31:0] d, input string name);
        cmd_t c;
        c.cy = cy; c.rasn = rasn; c.casn = casn; c.wen = wen;
        c.chk_a = chk_a; c.a = a; c.chk_d = chk_d; c.d = d; c.name = name;
        return c;
    endfunction

    // Command monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (DRAM_CSn === 1'b0) begin
                if (cmd_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_cmd: got RASn=%b CASn=%b WEn=%h A=%h, expected none (cycle %0d)",
                             DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A, cyc);
                end else begin
                    cmd_t e;
                    e = cmd_q.pop_front();
                    check($sformatf("%s_cycle", e.name), 64'(cyc), 64'(e.cy));
                    check($sformatf("%s_strobes", e.name), {DRAM_RASn, DRAM_CASn, DRAM_WEn},
                          {e.rasn, e.casn, e.wen});
                    if (e.chk_a) check($sformatf("%s_addr", e.name), DRAM_A, e.a);
                    if (e.chk_d) check($sformatf("%s_data", e.name), DRAM_D, e.d);
                end
            end else begin
                check("idle_strobes", {DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn}, 7'h7F);
            end
        end
    end

    // Response monitor
    bit resp_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            resp_prev = 1'b0;
        end else begin
            if (resp_prev) check("ready_after_resp", req_ready, 1'b1);
            resp_prev = (resp_valid === 1'b1);
            if (resp_valid === 1'b1) begin
                check("ready_during_resp", req_ready, 1'b0);
                if (rsp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got resp_valid err=%b rdata=%h, expected none (cycle %0d)",
                             resp_err, resp_rdata, cyc);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    check("resp_cycle", 64'(cyc), 64'(r.cy));
                    check("resp_err", resp_err, r.err);
                    check(r.is_write ? "resp_rdata_hold" : "resp_rdata", resp_rdata, r.rdata);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, req_ready, 1'b1);
        check({tag, "_resp"}, {resp_valid, resp_err}, 2'b00);
        check({tag, "_rdata"}, resp_rdata, 32'h0);
        check({tag, "_strobes"}, {DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn}, 7'h7F);
        check({tag, "_a"}, DRAM_A, 11'h0);
        check({tag, "_d"}, DRAM_D, 32'h0);
    endtask

    // Issue one request and push everything the model predicts for it.
    task automatic start_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb, input int rdelay, input logic [31:0] rdata,
                             output int cas, output int rc);
        int guard, h, act, row, col;
        guard = 0;
        cas   = 0;
        rc    = 0;
        row   = int'((addr >> (COL_BITS + 2)) % (32'd1 << ROW_BITS));
        col   = int'((addr >> 2) % (32'd1 << COL_BITS));
        @(negedge clk);
        while (req_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (req_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_ready_wait: got req_ready=%b, expected 1 within 200 cycles", req_ready);
            return;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        h = cyc;
        if (m_open && m_row == row) begin
            cas = h + 1;
        end else begin
            if (m_open) begin
                cmd_q.push_back(mk(h + 1, 1'b0, 1'b1, 4'h0, 1'b0, 11'h0, 1'b0, 32'h0, "PRE"));
                act = h + 1 + T_RP;
            end else begin
                act = h + 1;
            end
            cmd_q.push_back(mk(act, 1'b0, 1'b1, 4'hF, 1'b1, 11'(row), 1'b0, 32'h0, "ACT"));
            cas = act + T_RCD;
        end
        m_open = 1'b1;
        m_row  = row;
        if (wr) begin
            cmd_q.push_back(mk(cas, 1'b1, 1'b0, ~strb, 1'b1, 11'(col), 1'b1, wdata, "WR"));
            rc = cas + T_WR + 1;
            rsp_q.push_back('{rc, 1'b1, 1'b0, m_rdata});
        end else begin
            cmd_q.push_back(mk(cas, 1'b1, 1'b0, 4'hF, 1'b1, 11'(col), 1'b0, 32'h0, "RD"));
            if (rdelay > 0) begin
                rc = cas + rdelay + 1;
                rsp_q.push_back('{rc, 1'b0, 1'b0, rdata});
                m_rdata = rdata;
            end else begin
                rc = cas + T_OUT + 1;
                rsp_q.push_back('{rc, 1'b0, 1'b1, 32'h0});
                m_rdata = '0;
                m_open  = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
    endtask

    task automatic pulse_dram(input logic [31:0] q);
        DRAM_valid = 1'b1;
        DRAM_Q     = q;
        @(negedge clk);
        DRAM_valid = 1'b0;
        DRAM_Q     = $urandom;
    endtask

    // Full transaction: request, play the DRAM side, wait for the predicted response.
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int rdelay, input logic [31:0] rdata,
                          input bit idle_spur);
        int cas, rc;
        start_req(wr, addr, wdata, strb, rdelay, rdata, cas, rc);
        if (rc == 0) return;
        @(negedge clk);
        if (!wr && rdelay > 0) begin
            while (cyc < cas + rdelay) @(negedge clk);
            pulse_dram(rdata);
        end else if (wr) begin
            while (cyc < cas + 2) @(negedge clk);
            pulse_dram($urandom);
        end
        while (cyc < rc) @(negedge clk);
        if (idle_spur) begin
            @(negedge clk);
            pulse_dram($urandom);
        end
    endtask

    task automatic reset_in_trcd(input logic [31:0] addr);
        int cas, rc;
        start_req(1'b0, addr, 32'h0, 4'h0, 1, 32'h0, cas, rc);
        if (rc == 0) return;
        // ACT lands at cas - T_RCD; two cycles later the controller is waiting out tRCD.
        while (cyc < cas - T_RCD + 2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_trcd");
        cmd_q.delete();
        rsp_q.delete();
        m_open  = 1'b0;
        m_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wstrb  = '0;
        DRAM_Q     = '0;
        DRAM_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        do_req(1'b0, 32'h0000_1004, 32'h0, 4'h0, 3, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b1, 32'h0000_1008, 32'h1234_5678, 4'b0101, 0, 32'h0, 1'b1);
        do_req(1'b0, 32'h0000_2000, 32'h0, 4'h0, 1, 32'hA5A5_0001, 1'b0);
        do_req(1'b0, 32'h0000_2004, 32'h0, 4'h0, 2, 32'h5A5A_0002, 1'b1);
        do_req(1'b0, 32'h0000_2008, 32'h0, 4'h0, 0, 32'h0, 1'b0);
        do_req(1'b0, 32'h0000_200C, 32'h0, 4'h0, 4, 32'hC0DE_0003, 1'b0);
        reset_in_trcd(32'h0000_5000);
        do_req(1'b0, 32'h0000_5004, 32'h0, 4'h0, 1, 32'h0BAD_F00D, 1'b0);
        do_req(1'b1, 32'h0000_5010, 32'hFFFF_0000, 4'h0, 0, 32'h0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] addr;
            int          rows [4] = '{1, 2, 3, 1023};
            int          rd;
            addr = {9'($urandom), 11'(rows[$urandom_range(0, 3)]), 10'($urandom), 2'($urandom)};
            rd   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 10);
            do_req(1'($urandom), addr, $urandom, 4'($urandom), rd, $urandom, 1'($urandom));
        end

        repeat (5) @(negedge clk);
        check("cmd_queue_empty", 64'(cmd_q.size()), 64'd0);
        check("resp_queue_empty", 64'(rsp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
